if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 34 +++
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
// Holds the fetch FSM state type, the NOP encoding inserted into IF/ID, the default reset PC and
// the base opcode constants that the decoder also uses.
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INS          = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Base opcodes (ins[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    StBoot,
    StReq,
    StWait,
    StHold,
    StDrop
  } fetch_state_e;

  // True for opcodes that can redirect the fetch stream.
  function automatic logic is_ctrl_flow(input logic [31:0] ins);
    return (ins[6:0] == OPC_JAL) || (ins[6:0] == OPC_JALR) || (ins[6:0] == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage.
// Issues one fetch at a time to the instruction memory, captures the response into the IF/ID
// register, buffers a response that lands during a stall, and redirects on flush from decode.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   stall             freeze PC and IF/ID
//   flush             redirect to redirect_pc (takes priority over stall)
//   redirect_pc       redirect target, low two bits ignored
//   imem_req/addr     one-cycle fetch request pulse and address
//   imem_valid/rdata  memory response strobe and instruction
//   if_id_ins/pc      IF/ID instruction and its PC
//   if_id_valid       IF/ID holds a real fetched instruction
module if_stage #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INS  = riscv_pkg::NOP_INS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_ins,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);
  import riscv_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  ins_d, ins_pc_d;
  logic         ins_valid_d;

  // Redirect targets are word aligned; the low bits are dropped.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    hold_d      = hold_q;
    ins_d       = if_id_ins;
    ins_pc_d    = if_id_pc;
    ins_valid_d = if_id_valid;

    unique case (state_q)
      StBoot: state_d = StReq;
      StReq:  state_d = StWait;
      StWait: begin
        if (imem_valid) begin
          if (stall) begin
            hold_d  = imem_rdata;
            state_d = StHold;
          end else begin
            ins_d       = imem_rdata;
            ins_pc_d    = pc_q;
            ins_valid_d = 1'b1;
            pc_d        = pc_q + 32'd4;
            state_d     = StReq;
          end
        end
      end
      StHold: begin
        if (!stall) begin
          ins_d       = hold_q;
          ins_pc_d    = pc_q;
          ins_valid_d = 1'b1;
          pc_d        = pc_q + 32'd4;
          state_d     = StReq;
        end
      end
      StDrop: begin
        if (imem_valid) state_d = StReq;
      end
      default: state_d = StBoot;
    endcase

    if (flush) begin
      pc_d        = {redirect_pc[31:2], 2'b00};
      ins_d       = NOP_INS;
      ins_pc_d    = if_id_pc;
      ins_valid_d = 1'b0;
      hold_d      = hold_q;
      unique case (state_q)
        // The request already on the bus will still answer; swallow it.
        StReq:   state_d = StDrop;
        StWait:  state_d = imem_valid ? StReq : StDrop;
        StHold:  state_d = StReq;
        // Boot and Drop keep their own progression; only the PC moves. Drop still leaves on the
        // pending response so it cannot deadlock waiting for one that already came.
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      hold_q      <= '0;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      if_id_ins   <= NOP_INS;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      hold_q      <= hold_d;
      // Registered request: asserted exactly for the cycle spent in Req.
      imem_req    <= (state_d == StReq);
      imem_addr   <= pc_d;
      if_id_ins   <= ins_d;
      if_id_pc    <= ins_pc_d;
      if_id_valid <= ins_valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small behavioural instruction memory of selectable latency.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_ins;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  localparam logic [31:0] Nop = 32'h0000_0013;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .if_id_ins   (if_id_ins),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0093 : (a ^ 32'hA500_0013);
  endfunction

  // Memory model: one outstanding request, latency mem_lat (1 or 2), cleared by rst.
  logic [1:0]  mem_lat;
  logic        mem_busy;
  logic [1:0]  mem_cnt;
  logic [31:0] mem_addr;

  always @(posedge clk) begin
    if (rst) begin
      imem_valid <= 1'b0;
      imem_rdata <= '0;
      mem_busy   <= 1'b0;
      mem_cnt    <= '0;
      mem_addr   <= '0;
    end else begin
      imem_valid <= 1'b0;
      if (imem_req) begin
        if (mem_lat == 2'd1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(imem_addr);
        end else begin
          mem_busy <= 1'b1;
          mem_cnt  <= mem_lat - 2'd1;
          mem_addr <= imem_addr;
        end
      end else if (mem_busy) begin
        if (mem_cnt == 2'd1) begin
          imem_valid <= 1'b1;
          imem_rdata <= mem_word(mem_addr);
          mem_busy   <= 1'b0;
        end else begin
          mem_cnt <= mem_cnt - 2'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect_pc = '0;
    mem_lat     = 2'd1;
    repeat (3) @(negedge clk);

    // Cycle 0: reset values
    check("rst_req",   imem_req,    0);
    check("rst_addr",  imem_addr,   0);
    check("rst_ins",   if_id_ins,   Nop);
    check("rst_pc",    if_id_pc,    0);
    check("rst_valid", if_id_valid, 0);
    rst = 1'b0;

    step();  // c1: Req
    check("c1_req",  imem_req,  1);
    check("c1_addr", imem_addr, 0);
    step();  // c2: Wait
    check("c2_req",   imem_req,    0);
    check("c2_valid", if_id_valid, 0);
    step();  // c3: IF/ID loaded, next request
    check("c3_ins",   if_id_ins,   32'h0000_0093);
    check("c3_pc",    if_id_pc,    0);
    check("c3_valid", if_id_valid, 1);
    check("c3_req",   imem_req,    1);
    check("c3_addr",  imem_addr,   4);

    // Stall across the response: three Hold cycles
    stall = 1'b1;
    step();  // c4: Wait with response
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_ins", if_id_ins, 32'h0000_0093);
      check("hold_pc",  if_id_pc,  0);
      check("hold_req", imem_req,  0);
    end
    stall = 1'b0;
    step();  // c8
    check("unhold_ins",   if_id_ins,   mem_word(32'h4));
    check("unhold_pc",    if_id_pc,    32'h4);
    check("unhold_valid", if_id_valid, 1);
    check("unhold_req",   imem_req,    1);
    check("unhold_addr",  imem_addr,   32'h8);

    // Flush while Wait has no response yet
    mem_lat = 2'd2;
    step();  // c9: Wait, pending
    check("c9_req", imem_req, 0);
    flush       = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();  // c10: Drop
    check("fw_ins",   if_id_ins,   Nop);
    check("fw_valid", if_id_valid, 0);
    check("fw_req",   imem_req,    0);
    flush = 1'b0;
    step();  // c11: Req to target, stale response swallowed
    check("fw_req2",   imem_req,    1);
    check("fw_addr",   imem_addr,   32'h0000_0100);
    check("fw_ins2",   if_id_ins,   Nop);
    check("fw_valid2", if_id_valid, 0);
    mem_lat = 2'd1;
    step();  // c12
    step();  // c13
    check("tgt_ins",  if_id_ins,   mem_word(32'h100));
    check("tgt_pc",   if_id_pc,    32'h100);
    check("tgt_val",  if_id_valid, 1);
    check("tgt_addr", imem_addr,   32'h104);

    // Flush together with stall while in Hold
    stall = 1'b1;
    step();  // c14: Wait with response
    step();  // c15: Hold
    check("h_ins", if_id_ins, mem_word(32'h100));
    flush       = 1'b1;
    redirect_pc = 32'h0000_0200;
    step();  // c16
    check("fh_req",   imem_req,    1);
    check("fh_addr",  imem_addr,   32'h200);
    check("fh_ins",   if_id_ins,   Nop);
    check("fh_valid", if_id_valid, 0);
    flush = 1'b0;
    stall = 1'b0;
    step();  // c17
    step();  // c18
    check("fh_ins2", if_id_ins, mem_word(32'h200));
    check("fh_pc2",  if_id_pc,  32'h200);

    // PC wrap: redirect from Req to the last word (low bits masked)
    flush       = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();  // c19: Drop
    check("wr_req0", imem_req, 0);
    flush = 1'b0;
    step();  // c20
    check("wr_req",  imem_req,  1);
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step();  // c21
    step();  // c22
    check("wr_ins",   if_id_ins, mem_word(32'hFFFF_FFFC));
    check("wr_pc",    if_id_pc,  32'hFFFF_FFFC);
    check("wr_req2",  imem_req,  1);
    check("wr_addr2", imem_addr, 32'h0000_0000);

    // Reset mid-Wait with a response still pending
    mem_lat = 2'd2;
    step();  // c23
    rst = 1'b1;
    step();  // c24
    check("mr_req",   imem_req,    0);
    check("mr_addr",  imem_addr,   0);
    check("mr_ins",   if_id_ins,   Nop);
    check("mr_pc",    if_id_pc,    0);
    check("mr_valid", if_id_valid, 0);
    check("mr_imem",  imem_valid,  0);
    rst = 1'b0;
    step();  // c25: Boot -> Req
    check("mr_req2",  imem_req,  1);
    check("mr_addr2", imem_addr, 0);
    step();  // c26
    check("mr_valid2", if_id_valid, 0);
    step();  // c27
    step();  // c28
    check("mr_ins3",   if_id_ins,   32'h0000_0093);
    check("mr_valid3", if_id_valid, 1);
    check("mr_addr3",  imem_addr,   32'h4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
